// File: rtl/pia_pkg.sv
// Shared constants for the multi-port PIA: chip-select code, control register
// bit positions, C2 mode encodings and the C2 line state type.
package pia_pkg;

    localparam logic [2:0] CHIP_SELECTED = 3'b011;

    localparam int CR_IRQ1_FLAG  = 7;
    localparam int CR_IRQ2_FLAG  = 6;
    localparam int CR_C2_MODE_HI = 5;
    localparam int CR_C2_EDGE    = 4;
    localparam int CR_C2_MODE_LO = 3;
    localparam int CR_IRQ2_EN    = 3;
    localparam int CR_DDR_SEL    = 2;
    localparam int CR_C1_EDGE    = 1;
    localparam int CR_IRQ1_EN    = 0;

    // Input mode is any code with bit 2 clear; manual mode carries the level in bit 0.
    localparam logic [2:0] C2_IN    = 3'b000;
    localparam logic [2:0] C2_HSHK  = 3'b100;
    localparam logic [2:0] C2_PULSE = 3'b101;
    localparam logic [2:0] C2_MAN   = 3'b110;

    localparam logic RS_DATA = 1'b0;
    localparam logic RS_CTRL = 1'b1;

    typedef enum logic [1:0] {
        C2S_IN,
        C2S_HSHK,
        C2S_PULSE,
        C2S_MAN
    } c2_state_t;

    function automatic c2_state_t mode_to_state(input logic [2:0] mode);
        if (mode[2] == C2_IN[2])        return C2S_IN;
        else if (mode == C2_HSHK)       return C2S_HSHK;
        else if (mode == C2_PULSE)      return C2S_PULSE;
        else                            return C2S_MAN;
    endfunction

endpackage

// File: rtl/pia_port_ctl.sv
// One PIA port: CR/DDR/PO registers, C1/C2 edge detection, IRQ flags,
// the C2 output state machine and the registered irq_n.
module pia_port_ctl
    import pia_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sel,
    input  logic             i_rs0,
    input  logic             i_rw,
    input  logic [WIDTH-1:0] i_di,
    input  logic [WIDTH-1:0] i_pi,
    input  logic             i_c1,
    input  logic             i_c2i,
    output logic [WIDTH-1:0] o_rdata,
    output logic [WIDTH-1:0] o_po,
    output logic [WIDTH-1:0] o_ddr,
    output logic             o_c2o,
    output logic             o_irq_n
);

    logic [7:0]       r_cr;
    logic [WIDTH-1:0] r_ddr;
    logic [WIDTH-1:0] r_po;
    logic             r_c1_q;
    logic             r_c2_q;
    logic             r_c2o;
    logic             r_irq_n;
    c2_state_t        r_c2_state;

    logic             w_c1_edge;
    logic             w_c2_edge;
    logic             w_data_acc;
    logic             w_data_rd;
    logic             w_ctrl_wr;
    logic             w_ddr_wr;
    logic             w_po_wr;
    logic [7:0]       w_cr_nxt;
    c2_state_t        w_state_nxt;
    logic             w_c2o_nxt;
    logic             w_irq_n_nxt;

    assign w_c1_edge  = (r_c1_q != i_c1) && (i_c1 == r_cr[CR_C1_EDGE]);
    assign w_c2_edge  = (r_c2_q != i_c2i) && (i_c2i == r_cr[CR_C2_EDGE]);
    assign w_data_acc = i_sel && (i_rs0 == RS_DATA) && r_cr[CR_DDR_SEL];
    assign w_data_rd  = w_data_acc && i_rw;
    assign w_ctrl_wr  = i_sel && (i_rs0 == RS_CTRL) && !i_rw;
    assign w_ddr_wr   = i_sel && (i_rs0 == RS_DATA) && !i_rw && !r_cr[CR_DDR_SEL];
    assign w_po_wr    = w_data_acc && !i_rw;

    // Flag priority: read-clear first, then edge-set, then the CR[5] write-clear of IRQ2.
    always_comb begin
        w_cr_nxt = r_cr;
        if (w_ctrl_wr)
            w_cr_nxt[5:0] = i_di[5:0];
        if (w_data_rd) begin
            w_cr_nxt[CR_IRQ1_FLAG] = 1'b0;
            w_cr_nxt[CR_IRQ2_FLAG] = 1'b0;
        end
        if (w_c1_edge)
            w_cr_nxt[CR_IRQ1_FLAG] = 1'b1;
        if (w_c2_edge && !r_cr[CR_C2_MODE_HI])
            w_cr_nxt[CR_IRQ2_FLAG] = 1'b1;
        if (w_ctrl_wr && i_di[CR_C2_MODE_HI])
            w_cr_nxt[CR_IRQ2_FLAG] = 1'b0;
    end

    always_comb begin
        w_state_nxt = mode_to_state(w_cr_nxt[CR_C2_MODE_HI:CR_C2_MODE_LO]);
        w_c2o_nxt   = 1'b1;
        case (w_state_nxt)
            C2S_IN:    w_c2o_nxt = 1'b1;
            C2S_HSHK: begin
                if (w_data_acc)
                    w_c2o_nxt = 1'b0;
                else if (w_c1_edge || (r_c2_state != C2S_HSHK))
                    w_c2o_nxt = 1'b1;
                else
                    w_c2o_nxt = r_c2o;
            end
            C2S_PULSE: w_c2o_nxt = !w_data_acc;
            C2S_MAN:   w_c2o_nxt = w_cr_nxt[CR_C2_MODE_LO];
            default:   w_c2o_nxt = 1'b1;
        endcase
        w_irq_n_nxt = !((w_cr_nxt[CR_IRQ1_FLAG] & w_cr_nxt[CR_IRQ1_EN]) |
                        (w_cr_nxt[CR_IRQ2_FLAG] & w_cr_nxt[CR_IRQ2_EN] & ~w_cr_nxt[CR_C2_MODE_HI]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr       <= '0;
            r_ddr      <= '0;
            r_po       <= '0;
            r_c1_q     <= 1'b0;
            r_c2_q     <= 1'b0;
            r_c2o      <= 1'b1;
            r_irq_n    <= 1'b1;
            r_c2_state <= C2S_IN;
        end else begin
            r_cr       <= w_cr_nxt;
            r_c1_q     <= i_c1;
            r_c2_q     <= i_c2i;
            r_c2o      <= w_c2o_nxt;
            r_irq_n    <= w_irq_n_nxt;
            r_c2_state <= w_state_nxt;
            if (w_ddr_wr)
                r_ddr <= i_di;
            if (w_po_wr)
                r_po <= i_di;
        end
    end

    always_comb begin
        if (i_rs0 == RS_CTRL)
            o_rdata = WIDTH'(r_cr);
        else if (r_cr[CR_DDR_SEL])
            o_rdata = (r_po & r_ddr) | (i_pi & ~r_ddr);
        else
            o_rdata = r_ddr;
    end

    assign o_po    = r_po;
    assign o_ddr   = r_ddr;
    assign o_c2o   = r_c2o;
    assign o_irq_n = r_irq_n;

endmodule

// File: rtl/pia_multi.sv
// Multi-port PIA top: chip-select / register-select decode, registered read
// data and the combined interrupt output; per-port logic lives in pia_port_ctl.
module pia_multi
    import pia_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  NPORTS = 2,
    localparam int RSW    = $clog2(NPORTS) + 1
) (
    input  logic                    enable,
    input  logic                    reset_n,
    input  logic [2:0]              CS,
    input  logic [RSW-1:0]          RS,
    input  logic                    rw,
    input  logic [WIDTH-1:0]        DI,
    output logic [WIDTH-1:0]        DO,
    input  logic [NPORTS*WIDTH-1:0] PI,
    output logic [NPORTS*WIDTH-1:0] PO,
    output logic [NPORTS*WIDTH-1:0] POE,
    input  logic [NPORTS-1:0]       C1,
    input  logic [NPORTS-1:0]       C2I,
    output logic [NPORTS-1:0]       C2O,
    output logic [NPORTS-1:0]       irq_n,
    output logic                    irq_any_n
);

    logic             w_chip_sel;
    logic [RSW-1:0]   w_port_idx;
    logic [WIDTH-1:0] w_rdata [NPORTS];
    logic [WIDTH-1:0] w_do_nxt;
    logic [WIDTH-1:0] r_do;

    assign w_chip_sel = (CS == CHIP_SELECTED);
    assign w_port_idx = RS >> 1;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        pia_port_ctl #(
            .WIDTH (WIDTH)
        ) u_port (
            .clk     (enable),
            .rst_n   (reset_n),
            .i_sel   (w_chip_sel && (w_port_idx == RSW'(gi))),
            .i_rs0   (RS[0]),
            .i_rw    (rw),
            .i_di    (DI),
            .i_pi    (PI[gi*WIDTH +: WIDTH]),
            .i_c1    (C1[gi]),
            .i_c2i   (C2I[gi]),
            .o_rdata (w_rdata[gi]),
            .o_po    (PO[gi*WIDTH +: WIDTH]),
            .o_ddr   (POE[gi*WIDTH +: WIDTH]),
            .o_c2o   (C2O[gi]),
            .o_irq_n (irq_n[gi])
        );
    end

    // Indices beyond the last port leave the default of zero.
    always_comb begin
        w_do_nxt = '0;
        for (int i = 0; i < NPORTS; i++)
            if (w_port_idx == RSW'(i))
                w_do_nxt = w_rdata[i];
    end

    always_ff @(posedge enable or negedge reset_n) begin
        if (!reset_n)
            r_do <= '0;
        else if (w_chip_sel && rw)
            r_do <= w_do_nxt;
    end

    assign DO        = r_do;
    assign irq_any_n = &irq_n;

endmodule

// File: tb/tb_pia_multi.sv
// Directed bench for pia_multi with three 8-bit ports: reset, DDR-masked
// readback, C1/C2 flags and IRQs, C2 handshake/pulse/manual modes, decode.
module tb_pia_multi;

    localparam int W  = 8;
    localparam int NP = 3;

    logic            enable = 1'b0;
    logic            reset_n;
    logic [2:0]      CS;
    logic [2:0]      RS;
    logic            rw;
    logic [W-1:0]    DI;
    logic [W-1:0]    DO;
    logic [NP*W-1:0] PI;
    logic [NP*W-1:0] PO;
    logic [NP*W-1:0] POE;
    logic [NP-1:0]   C1;
    logic [NP-1:0]   C2I;
    logic [NP-1:0]   C2O;
    logic [NP-1:0]   irq_n;
    logic            irq_any_n;

    int checks = 0;
    int errors = 0;

    pia_multi #(
        .WIDTH  (W),
        .NPORTS (NP)
    ) dut (
        .enable    (enable),
        .reset_n   (reset_n),
        .CS        (CS),
        .RS        (RS),
        .rw        (rw),
        .DI        (DI),
        .DO        (DO),
        .PI        (PI),
        .PO        (PO),
        .POE       (POE),
        .C1        (C1),
        .C2I       (C2I),
        .C2O       (C2O),
        .irq_n     (irq_n),
        .irq_any_n (irq_any_n)
    );

    always #5 enable = ~enable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: set up after a falling edge, committed on the next rising edge.
    task automatic bus(input logic [1:0] port, input logic rs0, input logic rd, input logic [7:0] data);
        @(negedge enable);
        CS = 3'b011;
        RS = {port, rs0};
        rw = rd;
        DI = data;
        @(negedge enable);
        CS = 3'b000;
        rw = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        CS      = 3'b000;
        RS      = '0;
        rw      = 1'b1;
        DI      = '0;
        PI      = '0;
        PI[7:0] = 8'h3C;
        C1      = '0;
        C2I     = '0;

        // Reset state
        @(negedge enable);
        @(negedge enable);
        check("rst_do", DO, 8'h00);
        check("rst_po", PO, 24'h0);
        check("rst_poe", POE, 24'h0);
        check("rst_c2o", C2O, 3'b111);
        check("rst_irq_n", irq_n, 3'b111);
        check("rst_irq_any", irq_any_n, 1'b1);
        reset_n = 1'b1;

        // DDR-masked readback on port 0
        bus(2'd0, 1'b0, 1'b0, 8'hF0);
        bus(2'd0, 1'b1, 1'b0, 8'h04);
        bus(2'd0, 1'b0, 1'b0, 8'hA5);
        bus(2'd0, 1'b0, 1'b1, 8'h00);
        check("ddr_mix_read", DO, 8'hAC);
        check("ddr_mix_poe", POE, 24'h0000F0);
        check("ddr_mix_po", PO, 24'h0000A5);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("ddr_mix_cr", DO, 8'h04);

        // Reset pulse between edges clears everything without a clock edge
        @(negedge enable);
        #2 reset_n = 1'b0;
        #1;
        check("rstp_do", DO, 8'h00);
        check("rstp_po", PO, 24'h0);
        check("rstp_poe", POE, 24'h0);
        check("rstp_c2o", C2O, 3'b111);
        check("rstp_irq_n", irq_n, 3'b111);
        #1 reset_n = 1'b1;

        // C1 rising edge sets IRQ1, data read clears it
        bus(2'd0, 1'b1, 1'b0, 8'h07);
        C1[0] = 1'b1;
        @(negedge enable);
        check("c1_irq_n", irq_n, 3'b110);
        check("c1_irq_any", irq_any_n, 1'b0);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("c1_cr_flag", DO, 8'h87);
        bus(2'd0, 1'b0, 1'b1, 8'h00);
        check("c1_read_data", DO, 8'h3C);
        check("c1_clr_irq_n", irq_n, 3'b111);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("c1_cr_clr", DO, 8'h07);

        // Edge on the same cycle as the clearing read: flag stays set
        C1[0] = 1'b0;
        @(negedge enable);
        CS    = 3'b011;
        RS    = {2'd0, 1'b0};
        rw    = 1'b1;
        C1[0] = 1'b1;
        @(negedge enable);
        CS = 3'b000;
        check("c1_same_irq_n", irq_n[0], 1'b0);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("c1_same_cr", DO, 8'h87);
        bus(2'd0, 1'b0, 1'b1, 8'h00);
        check("c1_final_clr", irq_n, 3'b111);

        // C2 input interrupt on port 1, then manual output levels
        bus(2'd1, 1'b1, 1'b0, 8'h1C);
        C2I[1] = 1'b1;
        @(negedge enable);
        check("c2_irq_n", irq_n, 3'b101);
        check("c2_irq_any", irq_any_n, 1'b0);
        bus(2'd1, 1'b1, 1'b1, 8'h00);
        check("c2_cr_flag", DO, 8'h5C);
        bus(2'd1, 1'b1, 1'b0, 8'h3C);
        bus(2'd1, 1'b1, 1'b1, 8'h00);
        check("c2_cr_clr", DO, 8'h3C);
        check("c2_clr_irq_n", irq_n, 3'b111);
        check("man_hi", C2O, 3'b111);
        bus(2'd1, 1'b1, 1'b0, 8'h34);
        check("man_lo", C2O, 3'b101);
        bus(2'd1, 1'b1, 1'b0, 8'h3C);
        check("man_hi2", C2O, 3'b111);

        // Handshake on port 0 with falling-edge C1
        bus(2'd0, 1'b1, 1'b0, 8'h24);
        check("hs_enter", C2O[0], 1'b1);
        bus(2'd0, 1'b0, 1'b0, 8'h55);
        check("hs_low", C2O[0], 1'b0);
        check("hs_po", PO, 24'h000055);
        @(negedge enable);
        check("hs_hold", C2O[0], 1'b0);
        C1[0] = 1'b0;
        @(negedge enable);
        check("hs_release", C2O[0], 1'b1);

        // Pulse mode: exactly one low cycle after a data read
        bus(2'd0, 1'b1, 1'b0, 8'h2C);
        check("pulse_idle", C2O[0], 1'b1);
        bus(2'd0, 1'b0, 1'b1, 8'h00);
        check("pulse_low", C2O[0], 1'b0);
        check("pulse_read", DO, 8'h3C);
        @(negedge enable);
        check("pulse_end", C2O[0], 1'b1);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("pulse_cr", DO, 8'h2C);

        // Wrong chip select is ignored and DO holds
        @(negedge enable);
        CS = 3'b111;
        RS = {2'd0, 1'b1};
        rw = 1'b0;
        DI = 8'hFF;
        @(negedge enable);
        RS = {2'd0, 1'b0};
        @(negedge enable);
        CS = 3'b000;
        rw = 1'b1;
        check("cs_po", PO, 24'h000055);
        check("cs_do_hold", DO, 8'h2C);
        bus(2'd0, 1'b1, 1'b1, 8'h00);
        check("cs_cr", DO, 8'h2C);

        // Port index beyond NPORTS
        bus(2'd3, 1'b0, 1'b0, 8'hFF);
        bus(2'd3, 1'b0, 1'b1, 8'h00);
        check("oob_read", DO, 8'h00);
        check("oob_po", PO, 24'h000055);
        check("oob_poe", POE, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
